uart_tx_core: RTL and testbench

Parametrised UART transmit engine that serialises one frame per accepted word, with programmable data width, five parity modes, 1 or 2 stop bits, and a runtime baud divisor. It replaces the fixed-format transmit FSM in the UART peripheral. It sits between the CSR/TX FIFO (valid/ready stream) and the tx pin. It adds back-to-back frames with zero idle gap, break generation, and per-frame configuration latching.

---
 rtl/uart_tx_core_pkg.sv | 36 +++
 rtl/uart_tx_core_if.sv | 21 ++
 rtl/uart_tx_core_baud_tick.sv | 26 ++
 rtl/uart_tx_core.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_core.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_core_pkg.sv
// Shared types for the UART transmit core.
// Parity modes, FSM states and the data-width clamp helper.
package uart_tx_core_pkg;

    localparam int MIN_DATA_BITS = 5;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        EVEN  = 3'd1,
        ODD   = 3'd2,
        MARK  = 3'd3,
        SPACE = 3'd4
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        MARK_AFTER
    } tx_core_state_e;

    function automatic logic [3:0] clamp_bits(
        input logic [3:0] req,
        input logic [3:0] max_bits
    );
        if (req < 4'(MIN_DATA_BITS))
            return 4'(MIN_DATA_BITS);
        if (req > max_bits)
            return max_bits;
        return req;
    endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Word stream feeding the transmit core.
// The FIFO side is master, the core is slave.
interface uart_tx_if #(
    parameter int MAX_DATA_BITS = 9
);
    logic                     s_valid;
    logic                     s_ready;
    logic [MAX_DATA_BITS-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/uart_tx_core_baud_tick.sv
// Bit-period down-counter for the transmit core.
// o_tick marks the last clock of each bit.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == '0);

    // Restart on state entry, reload at each bit end, else count down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_div;
        else if (i_en)
            r_cnt <= (r_cnt == '0) ? i_div : r_cnt - DIV_W'(1);
    end
endmodule

// File: rtl/uart_tx_core.sv
// UART transmit engine: one frame per accepted word.
// Back-to-back frames, break generation, per-frame config latch.
module uart_tx_core
    import uart_tx_core_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int DIV_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_if.slave         sif,
    input  logic [DIV_W-1:0] cfg_baud_div,
    input  logic [3:0]       cfg_data_bits,
    input  logic [2:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic             break_req,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);
    tx_core_state_e           r_state;
    logic [MAX_DATA_BITS-1:0] r_shreg;
    logic [3:0]               r_nbits;
    logic [3:0]               r_bitcnt;
    parity_mode_e             r_par_mode;
    logic                     r_stop2;
    logic                     r_stopcnt;
    logic                     r_par;
    logic                     r_tx;
    logic [DIV_W-1:0]         r_div;

    logic             w_tick;
    logic             w_tick_en;
    logic             w_last_stop;
    logic             w_last_data;
    logic             w_end_frame;
    logic             w_ready;
    logic             w_xfer;
    logic             w_to_break;
    logic             w_load;
    logic [DIV_W-1:0] w_div_val;
    logic             w_acc;
    logic             w_par_bit;
    parity_mode_e     w_par_in;

    assign w_last_stop = !r_stop2 || r_stopcnt;
    assign w_last_data = (r_bitcnt == r_nbits - 4'd1);
    assign w_end_frame = (r_state == STOP) && w_tick && w_last_stop;

    // Ready is a pure function of state, never of s_valid
    assign w_ready    = rst_n && !break_req &&
                        ((r_state == IDLE) || w_end_frame);
    assign w_xfer     = sif.s_valid && w_ready;
    assign w_to_break = break_req &&
                        ((r_state == IDLE) || w_end_frame);

    assign w_tick_en = (r_state != IDLE) && (r_state != BREAK);
    assign w_load    = w_xfer || ((r_state == BREAK) && !break_req);
    assign w_div_val = w_xfer ? cfg_baud_div : r_div;

    assign w_par_in = (cfg_parity > 3'd4) ? NONE
                                          : parity_mode_e'(cfg_parity);

    assign sif.s_ready = w_ready;
    assign tx          = r_tx;
    assign busy        = (r_state != IDLE);
    assign frame_done  = w_end_frame;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_en   (w_tick_en),
        .i_div  (w_div_val),
        .o_tick (w_tick)
    );

    // Parity bit from all data bits, including the one on the line now
    always_comb begin
        w_acc     = r_par ^ r_shreg[0];
        w_par_bit = 1'b0;
        unique case (r_par_mode)
            EVEN:    w_par_bit = w_acc;
            ODD:     w_par_bit = ~w_acc;
            MARK:    w_par_bit = 1'b1;
            default: w_par_bit = 1'b0;
        endcase
    end

    // Frame FSM with registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_nbits    <= 4'(MIN_DATA_BITS);
            r_bitcnt   <= '0;
            r_par_mode <= NONE;
            r_stop2    <= 1'b0;
            r_stopcnt  <= 1'b0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_div      <= '0;
        end else if (w_xfer) begin
            r_state    <= START;
            r_tx       <= 1'b0;
            r_shreg    <= sif.s_data;
            r_nbits    <= clamp_bits(cfg_data_bits,
                                     4'(MAX_DATA_BITS));
            r_par_mode <= w_par_in;
            r_stop2    <= cfg_stop2;
            r_div      <= cfg_baud_div;
            r_bitcnt   <= '0;
            r_stopcnt  <= 1'b0;
            r_par      <= 1'b0;
        end else if (w_to_break) begin
            r_state <= BREAK;
            r_tx    <= 1'b0;
            r_div   <= cfg_baud_div;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                end
                START: begin
                    if (w_tick) begin
                        r_state  <= DATA;
                        r_tx     <= r_shreg[0];
                        r_bitcnt <= '0;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_par   <= w_acc;
                        r_shreg <= r_shreg >> 1;
                        if (!w_last_data) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                            r_tx     <= r_shreg[1];
                        end else if (r_par_mode != NONE) begin
                            r_state <= PARITY;
                            r_tx    <= w_par_bit;
                        end else begin
                            r_state   <= STOP;
                            r_tx      <= 1'b1;
                            r_stopcnt <= 1'b0;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_state   <= STOP;
                        r_tx      <= 1'b1;
                        r_stopcnt <= 1'b0;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (w_last_stop) begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end else begin
                            r_stopcnt <= 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (!break_req) begin
                        r_state <= MARK_AFTER;
                        r_tx    <= 1'b1;
                    end
                end
                MARK_AFTER: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core.
// Table vectors, random frames vs a bit-list model, corner sequences.
module tb_uart_tx_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_baud_div;
    logic [3:0]  cfg_data_bits;
    logic [2:0]  cfg_parity;
    logic        cfg_stop2;
    logic        break_req;
    logic        tx;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad = 0;

    bit exp_tx[$];
    bit exp_done[$];
    bit cap_tx[$];
    bit cap_done[$];
    bit cap_busy[$];
    bit cap_rdy[$];

    typedef struct {
        logic [8:0]  d;
        logic [15:0] div;
        logic [3:0]  nb;
        logic [2:0]  par;
        logic        st2;
        int          nbits;
        logic [12:0] bits;
    } vec_t;

    vec_t tbl[7];

    uart_tx_if #(.MAX_DATA_BITS(9)) sif ();

    uart_tx_core #(
        .MAX_DATA_BITS (9),
        .DIV_W         (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sif           (sif),
        .cfg_baud_div  (cfg_baud_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .break_req     (break_req),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    function automatic int qdiff(input bit a[$], input bit b[$]);
        int n;
        int m;
        n = (a.size() < b.size()) ? a.size() : b.size();
        m = (a.size() > b.size()) ? a.size() - b.size()
                                  : b.size() - a.size();
        for (int i = 0; i < n; i++)
            if (a[i] != b[i]) m++;
        return m;
    endfunction

    // Reference: list of bit values, each stretched to div+1 clocks
    task automatic model_frame(input logic [8:0] d, input int div,
                               input int nb, input int par,
                               input bit st2);
        bit b[$];
        int n;
        int ones;
        n = (nb < 5) ? 5 : ((nb > 9) ? 9 : nb);
        ones = 0;
        b.push_back(1'b0);
        for (int k = 0; k < n; k++) begin
            b.push_back(d[k]);
            ones += int'(d[k]);
        end
        if (par == 1) b.push_back(bit'(ones % 2));
        if (par == 2) b.push_back(bit'(1 - ones % 2));
        if (par == 3) b.push_back(1'b1);
        if (par == 4) b.push_back(1'b0);
        b.push_back(1'b1);
        if (st2) b.push_back(1'b1);
        foreach (b[i])
            for (int c = 0; c <= div; c++) begin
                exp_tx.push_back(b[i]);
                exp_done.push_back(1'b0);
            end
        exp_done[exp_done.size() - 1] = 1'b1;
    endtask

    task automatic expand_vec(input logic [12:0] v, input int nbits,
                              input int div);
        for (int i = 0; i < nbits; i++)
            for (int c = 0; c <= div; c++) begin
                exp_tx.push_back(v[i]);
                exp_done.push_back(1'b0);
            end
        exp_done[exp_done.size() - 1] = 1'b1;
    endtask

    task automatic clear_all();
        exp_tx.delete();
        exp_done.delete();
        cap_tx.delete();
        cap_done.delete();
        cap_busy.delete();
        cap_rdy.delete();
    endtask

    task automatic sample();
        cap_tx.push_back(tx);
        cap_done.push_back(frame_done);
        cap_busy.push_back(busy);
        cap_rdy.push_back(sif.s_ready);
    endtask

    task automatic compare_caps(input string nm);
        int nb0;
        nb0 = 0;
        foreach (cap_busy[i])
            if (!cap_busy[i]) nb0++;
        check({nm, " tx"}, qdiff(cap_tx, exp_tx), 0);
        check({nm, " done"}, qdiff(cap_done, exp_done), 0);
        check({nm, " busy"}, nb0, 0);
    endtask

    // One frame from IDLE; config and data scrambled right after handshake
    task automatic run_frame(input logic [8:0] d, input logic [15:0] div,
                             input logic [3:0] nb, input logic [2:0] par,
                             input logic st2, input string nm);
        int len;
        len = exp_tx.size();
        @(negedge clk);
        cfg_baud_div  = div;
        cfg_data_bits = nb;
        cfg_parity    = par;
        cfg_stop2     = st2;
        sif.s_data    = d;
        sif.s_valid   = 1'b1;
        check({nm, " ready"}, int'(sif.s_ready), 1);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) begin
                sif.s_valid   = 1'b0;
                sif.s_data    = 9'($urandom);
                cfg_baud_div  = 16'($urandom_range(0, 7));
                cfg_data_bits = 4'($urandom);
                cfg_parity    = 3'($urandom_range(0, 4));
                cfg_stop2     = 1'($urandom);
            end
            sample();
        end
        compare_caps(nm);
        @(negedge clk);
        check({nm, " idle"}, int'({tx, busy}), 2);
    endtask

    initial begin
        int nr;
        int ndone;
        int k;
        bit hs;
        logic [8:0] w[3];
        int tx_bad;
        int busy_bad;
        int rdy_cnt;
        int done_cnt;

        tbl[0] = '{9'h0A5, 16'd3, 4'd8, 3'd0, 1'b0, 10, 13'h034A};
        tbl[1] = '{9'h053, 16'd0, 4'd7, 3'd1, 1'b1, 11, 13'h06A6};
        tbl[2] = '{9'h053, 16'd0, 4'd7, 3'd2, 1'b0, 10, 13'h03A6};
        tbl[3] = '{9'h053, 16'd0, 4'd7, 3'd3, 1'b0, 10, 13'h03A6};
        tbl[4] = '{9'h053, 16'd0, 4'd7, 3'd4, 1'b0, 10, 13'h02A6};
        tbl[5] = '{9'h1F5, 16'd1, 4'd2, 3'd0, 1'b0, 7,  13'h006A};
        tbl[6] = '{9'h1A5, 16'd0, 4'd12, 3'd1, 1'b1, 13, 13'h1F4A};

        cfg_baud_div  = 16'd3;
        cfg_data_bits = 4'd8;
        cfg_parity    = 3'd0;
        cfg_stop2     = 1'b0;
        break_req     = 1'b0;
        sif.s_valid   = 1'b0;
        sif.s_data    = '0;

        // reset state, with a word offered during reset
        repeat (3) @(negedge clk);
        sif.s_valid = 1'b1;
        #1;
        check("rst tx", int'(tx), 1);
        check("rst busy", int'(busy), 0);
        check("rst ready", int'(sif.s_ready), 0);
        check("rst done", int'(frame_done), 0);
        sif.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors
        foreach (tbl[i]) begin
            clear_all();
            expand_vec(tbl[i].bits, tbl[i].nbits, int'(tbl[i].div));
            run_frame(tbl[i].d, tbl[i].div, tbl[i].nb, tbl[i].par,
                      tbl[i].st2, $sformatf("vec%0d", i));
        end

        // random frames against the model
        for (int r = 0; r < 25; r++) begin
            logic [8:0]  d;
            logic [15:0] dv;
            logic [3:0]  nb;
            logic [2:0]  p;
            logic        s2;
            d  = 9'($urandom);
            dv = 16'($urandom_range(0, 4));
            nb = 4'($urandom);
            p  = 3'($urandom_range(0, 4));
            s2 = 1'($urandom);
            clear_all();
            model_frame(d, int'(dv), int'(nb), int'(p), s2);
            run_frame(d, dv, nb, p, s2, $sformatf("rnd%0d", r));
        end

        // back-to-back: three words, s_valid held high
        clear_all();
        for (int i = 0; i < 3; i++) begin
            w[i] = 9'($urandom);
            model_frame(w[i], 1, 8, 0, 1'b0);
        end
        @(negedge clk);
        cfg_baud_div  = 16'd1;
        cfg_data_bits = 4'd8;
        cfg_parity    = 3'd0;
        cfg_stop2     = 1'b0;
        sif.s_data    = w[0];
        sif.s_valid   = 1'b1;
        check("b2b ready0", int'(sif.s_ready), 1);
        hs = sif.s_ready;
        k = 1;
        for (int i = 0; i < exp_tx.size(); i++) begin
            @(negedge clk);
            if (hs) begin
                if (k < 3) begin
                    sif.s_data = w[k];
                    k++;
                end else begin
                    sif.s_valid = 1'b0;
                end
            end
            sample();
            hs = sif.s_valid && sif.s_ready;
        end
        compare_caps("b2b");
        check("b2b ready", qdiff(cap_rdy, exp_done), 0);
        ndone = 0;
        foreach (cap_done[i])
            if (cap_done[i]) ndone++;
        check("b2b ndone", ndone, 3);
        check("b2b words", k, 3);
        sif.s_valid = 1'b0;
        @(negedge clk);
        check("b2b idle", int'({tx, busy}), 2);

        // break requested mid-frame
        clear_all();
        w[0] = 9'($urandom);
        model_frame(w[0], 2, 8, 0, 1'b0);
        @(negedge clk);
        cfg_baud_div  = 16'd2;
        cfg_data_bits = 4'd8;
        cfg_parity    = 3'd0;
        cfg_stop2     = 1'b0;
        sif.s_data    = w[0];
        sif.s_valid   = 1'b1;
        for (int i = 0; i < exp_tx.size(); i++) begin
            @(negedge clk);
            if (i == 12) begin
                break_req   = 1'b1;
                sif.s_valid = 1'b1;
            end
            if (i == 0) sif.s_valid = 1'b0;
            sample();
        end
        compare_caps("brk frame");
        nr = 0;
        foreach (cap_rdy[i])
            if (cap_rdy[i]) nr++;
        check("brk frame ready", nr, 0);
        tx_bad = 0;
        busy_bad = 0;
        rdy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx) tx_bad++;
            if (!busy) busy_bad++;
            if (sif.s_ready) rdy_cnt++;
            if (frame_done) done_cnt++;
        end
        break_req = 1'b0;
        sif.s_valid = 1'b0;
        check("brk low", tx_bad, 0);
        check("brk busy", busy_bad, 0);
        check("brk ready", rdy_cnt, 0);
        check("brk done", done_cnt, 0);
        tx_bad = 0;
        busy_bad = 0;
        rdy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!tx) tx_bad++;
            if (!busy) busy_bad++;
            if (sif.s_ready) rdy_cnt++;
            if (frame_done) rdy_cnt++;
        end
        check("mark high", tx_bad, 0);
        check("mark busy", busy_bad, 0);
        check("mark ready", rdy_cnt, 0);
        @(negedge clk);
        check("mark end", int'({tx, busy, sif.s_ready}), 5);

        // asynchronous reset in the DATA state
        @(negedge clk);
        cfg_baud_div  = 16'd3;
        cfg_data_bits = 4'd8;
        cfg_parity    = 3'd0;
        cfg_stop2     = 1'b0;
        sif.s_data    = 9'h03C;
        sif.s_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sif.s_valid = 1'b0;
        end
        check("pre rst busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid rst tx", int'(tx), 1);
        check("mid rst busy", int'(busy), 0);
        check("mid rst ready", int'(sif.s_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_all();
        model_frame(9'h0C3, 3, 8, 1, 1'b0);
        run_frame(9'h0C3, 16'd3, 4'd8, 3'd1, 1'b0, "post rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
